// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the 64-word data memory with bounded lock bursts,
// address checking with write suppression, and registered one-cycle read return.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        lock0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        lock1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_e;

  owner_e      owner_q, owner_d, gnt_owner;
  logic        last_q, last_d;
  logic [3:0]  count_q, count_d, count_nx;
  logic [1:0]  pend_q, pend_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        any_gnt, sel_we, sel_lock, bad, rd_ok;
  logic [31:0] sel_addr, sel_wd;

  // Grant: a live owner keeps the bus; otherwise a tie goes to the port not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (owner_q == OWN_P0 && req0)      gnt0 = 1'b1;
      else if (owner_q == OWN_P1 && req1) gnt1 = 1'b1;
      else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    gnt_owner = gnt1 ? OWN_P1 : OWN_P0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wd    = gnt1 ? wdata1 : wdata0;
    sel_we    = gnt1 ? we1    : we0;
    sel_lock  = gnt1 ? lock1  : lock0;
    bad       = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));
    rd_ok     = any_gnt && !sel_we && !bad;
    mem_a     = any_gnt ? sel_addr : 32'd0;
    mem_wd    = any_gnt ? sel_wd   : 32'd0;
    mem_we    = any_gnt && sel_we && !bad;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    owner_d  = owner_q;
    count_d  = count_q;
    last_d   = last_q;
    count_nx = 4'd0;
    if ((owner_q == OWN_P0 && !req0) || (owner_q == OWN_P1 && !req1)) begin
      owner_d = OWN_NONE;
      count_d = 4'd0;
    end
    if (any_gnt) begin
      if (sel_lock) begin
        count_nx = (owner_q == gnt_owner) ? count_q + 4'd1 : 4'd1;
        if (count_nx == 4'(MAX_BURST)) begin
          owner_d = OWN_NONE;
          count_d = 4'd0;
          last_d  = gnt1;
        end else begin
          owner_d = gnt_owner;
          count_d = count_nx;
        end
      end else begin
        owner_d = OWN_NONE;
        count_d = 4'd0;
        last_d  = gnt1;
      end
    end
  end

  // Completion data is registered so mem_rd never reaches an output combinationally.
  always_comb begin
    pend_d   = {gnt1, gnt0};
    err_d    = {gnt1 & bad, gnt0 & bad};
    rdata0_d = (gnt0 && rd_ok) ? mem_rd : 32'd0;
    rdata1_d = (gnt1 && rd_ok) ? mem_rd : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      last_q   <= 1'b1;
      count_q  <= 4'd0;
      pend_q   <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign rvalid0 = pend_q[0];
  assign rvalid1 = pend_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then constrained-random traffic, all
// checked each cycle against a behavioural model of arbitration, bursts and memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;
  localparam int WORDS     = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(WORDS), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Physical memory seen by the DUT; aliases on the low index bits so stray writes show up.
  logic [31:0] tb_mem [WORDS];
  always @(posedge clk) if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = tb_mem[mem_a[7:2]];

  // Reference model state.
  int          m_last, m_owner, m_burst;
  logic [31:0] ref_mem [WORDS];
  bit          exp_rv [2];
  bit          exp_err [2];
  logic [31:0] exp_rd [2];
  int          model_g, obs_g;
  int          n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit l);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
  endtask

  task automatic set1(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit l);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit          r [2], w [2], l [2];
    logic [31:0] a [2], d [2];
    int          g, idx;
    bit          bad;
    @(negedge clk);
    r = '{req0, req1}; w = '{we0, we1}; l = '{lock0, lock1};
    a = '{addr0, addr1}; d = '{wdata0, wdata1};
    g = -1;
    if (!reset) begin
      if (m_owner >= 0 && r[m_owner]) g = m_owner;
      else if (r[0] && r[1])          g = 1 - m_last;
      else if (r[0])                  g = 0;
      else if (r[1])                  g = 1;
    end
    bad = 1'b0;
    idx = 0;
    if (g >= 0) begin
      bad = (a[g][1:0] != 2'b00) || ((a[g] >> 2) >= 32'(WORDS));
      if (!bad) idx = int'(a[g] >> 2);
    end
    obs_g   = gnt0 ? 0 : (gnt1 ? 1 : -1);
    model_g = g;
    check("gnt0",    32'(gnt0),    32'(g == 0));
    check("gnt1",    32'(gnt1),    32'(g == 1));
    check("mem_we",  32'(mem_we),  32'(g >= 0 && w[g] && !bad));
    check("mem_a",   mem_a,        (g >= 0) ? a[g] : 32'd0);
    check("mem_wd",  mem_wd,       (g >= 0) ? d[g] : 32'd0);
    check("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
    check("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
    check("err0",    32'(err0),    32'(exp_err[0]));
    check("err1",    32'(err1),    32'(exp_err[1]));
    check("rdata0",  rdata0,       exp_rd[0]);
    check("rdata1",  rdata1,       exp_rd[1]);
    @(posedge clk);
    if (reset) begin
      m_last = 1; m_owner = -1; m_burst = 0;
      exp_rv = '{0, 0}; exp_err = '{0, 0}; exp_rd = '{32'd0, 32'd0};
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_rv[k]  = (g == k);
        exp_err[k] = (g == k) && bad;
        exp_rd[k]  = (g == k && !w[k] && !bad) ? ref_mem[idx] : 32'd0;
      end
      if (g >= 0 && w[g] && !bad) ref_mem[idx] = d[g];
      if (m_owner >= 0 && !r[m_owner]) begin
        m_owner = -1;
        m_burst = 0;
      end
      if (g >= 0) begin
        if (l[g]) begin
          if (m_owner == g) m_burst++;
          else begin
            m_owner = g;
            m_burst = 1;
          end
          if (m_burst == MAX_BURST) begin
            m_owner = -1; m_burst = 0; m_last = g;
          end
        end else begin
          m_owner = -1; m_burst = 0; m_last = g;
        end
      end
    end
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(64, 127)) << 2;
      1:       return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      2:       return $urandom();
      default: return 32'($urandom_range(0, 63)) << 2;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i]  = 32'd0;
      ref_mem[i] = 32'd0;
    end
    m_last = 1; m_owner = -1; m_burst = 0;
    exp_rv = '{0, 0}; exp_err = '{0, 0}; exp_rd = '{32'd0, 32'd0};
    reset = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;

    // Port 0 writes then reads word 4.
    set0(1, 1, 32'h10, 32'hDEADBEEF, 0); step();
    check("wr_gnt0", 32'(obs_g), 32'd0);
    set0(1, 0, 32'h10, 32'd0, 0); step();
    set0(0, 0, 0, 0, 0);
    check("rd_rvalid0", 32'(rvalid0), 32'd1);
    check("rd_beef",    rdata0,       32'hDEADBEEF);
    check("rd_err0",    32'(err0),    32'd0);
    set1(1, 0, 32'h0, 32'd0, 0); step();
    set1(0, 0, 0, 0, 0);

    // Unlocked tie: grants alternate starting with port 0.
    set0(1, 0, 32'h20, 32'd0, 0);
    set1(1, 0, 32'h24, 32'd0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("alt%0d", i), 32'(obs_g), 32'(i % 2));
    end
    set1(0, 0, 0, 0, 0);
    step();

    // Port 1 locked burst against a waiting port 0.
    set0(1, 0, 32'h28, 32'd0, 0);
    set1(1, 0, 32'h2C, 32'd0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("burst%0d", i), 32'(obs_g), (i < MAX_BURST) ? 32'd1 : 32'd0);
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Bad writes by port 1 are flagged and suppressed.
    set1(1, 1, 32'h100, 32'h12345678, 0); step();
    check("bad_hi_err", 32'(err1), 32'd1);
    check("bad_hi_rd",  rdata1,    32'd0);
    set1(1, 1, 32'h2, 32'h12345678, 0); step();
    check("bad_mis_err", 32'(err1), 32'd1);
    set1(1, 0, 32'h0, 32'd0, 0); step();
    check("readback0", rdata1, 32'd0);
    set1(0, 0, 0, 0, 0);

    // Locked port 0 drops request after two grants; relock restarts the count.
    set0(1, 0, 32'h30, 32'd0, 1);
    set1(1, 0, 32'h34, 32'd0, 0);
    step(); step();
    set0(0, 0, 0, 0, 0); step();
    check("drop_gnt1", 32'(obs_g), 32'd1);
    set0(1, 0, 32'h30, 32'd0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("relock%0d", i), 32'(obs_g), (i < MAX_BURST) ? 32'd0 : 32'd1);
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Reset while a request is present, then a tie favours port 0.
    set0(1, 0, 32'h10, 32'd0, 0);
    reset = 1'b1; step();
    reset = 1'b0;
    set0(0, 0, 0, 0, 0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    step();
    set0(1, 0, 32'h10, 32'd0, 0);
    set1(1, 0, 32'h14, 32'd0, 0);
    step();
    check("rst_tie_p0", 32'(obs_g), 32'd0);
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    step();

    // Random traffic: a port keeps its transaction stable until it is granted.
    for (int c = 0; c < 600; c++) begin
      if (!req0 || model_g == 0)
        set0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), pick_addr(), $urandom(),
             $urandom_range(0, 3) == 0);
      if (!req1 || model_g == 1)
        set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), pick_addr(), $urandom(),
             $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
